change_dispenser: RTL and testbench

- Output-side counterpart to the coin-accepting vending FSM. The vending FSM takes coins in. This block pays coins out.
- It accepts a change request in 5 rs units, the same encoding as the vending `change` output (0..4 = 0..20 rs).
- It drives a coin hopper one coin at a time over a valid/ack handshake, using a greedy 10 rs-first algorithm.
- It tracks on-board stock of 5 rs and 10 rs coins and reports any unpaid shortfall.

---
 rtl/change_dispenser_pkg.sv | 25 ++
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser_coin_stock.sv | 41 ++++
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_change_dispenser.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_pkg : shared state encoding and coin constants              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SELECT  = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic COIN_5  = 1'b0;
   localparam logic COIN_10 = 1'b1;
   localparam int   UNIT_RS = 5;

   // Value of a coin in request units (1 unit = UNIT_RS rupees).
   function automatic int unsigned coin_units(input logic coin_type);
      return (coin_type == COIN_10) ? 32'd2 : 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | change_dispenser_if : request and hopper handshake bundle        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface change_dispenser_if #(
   parameter int AMT_W = 3
);
   logic             req_valid;
   logic [AMT_W-1:0] req_amount;
   logic             req_ready;
   logic             coin_valid;
   logic             coin_type;
   logic             coin_ack;

   modport master (
      output req_valid, req_amount, coin_ack,
      input  req_ready, coin_valid, coin_type
   );

   modport slave (
      input  req_valid, req_amount, coin_ack,
      output req_ready, coin_valid, coin_type
   );
endinterface
`default_nettype wire

// File: rtl/change_dispenser_coin_stock.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coin_stock : saturating refill / decrement coin counter          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module coin_stock #(
   parameter int CNT_W = 8,
   parameter int INIT  = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             refill_i,
   input  wire logic [CNT_W-1:0] refill_amt_i,
   input  wire logic             dec_i,
   output logic      [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W:0]   sum_w;

   // One extra bit catches overflow so a coincident refill and decrement
   // resolves as cnt + refill - 1 before clamping.
   always_comb begin
      sum_w = {1'b0, cnt_q} + (refill_i ? {1'b0, refill_amt_i} : '0);
      if (dec_i && (sum_w != '0)) begin
         sum_w = sum_w - (CNT_W+1)'(1);
      end
      cnt_d = sum_w[CNT_W] ? '1 : sum_w[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= CNT_W'(INIT);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +------------------------------------------------------------------+
// | change_dispenser : greedy 10/5 rs coin payout; CHG_TIMEOUT_EN    |
// | adds an ack timeout and hopper_fault.   Rev 1.0                  |
// +------------------------------------------------------------------+
module change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W   = 3,
   parameter int CNT_W   = 8,
   parameter int INIT_5  = 16,
   parameter int INIT_10 = 16
`ifdef CHG_TIMEOUT_EN
   ,
   parameter int TO_CYC  = 255
`endif
) (
   input  wire logic             clk,
   input  wire logic             rst,
   change_dispenser_if.slave     bus,
   input  wire logic             refill_valid,
   input  wire logic [CNT_W-1:0] refill_5,
   input  wire logic [CNT_W-1:0] refill_10,
   output logic      [CNT_W-1:0] cnt_5,
   output logic      [CNT_W-1:0] cnt_10,
   output logic                  done,
   output logic      [AMT_W-1:0] shortfall,
   output logic                  low_stock
`ifdef CHG_TIMEOUT_EN
   ,
   output logic                  hopper_fault
`endif
);
   state_e           state_q;
   logic [AMT_W-1:0] rem_q;
   logic             coin_valid_q;
   logic             coin_type_q;
   logic             done_q;
   logic [AMT_W-1:0] shortfall_q;

   logic             ack_w;
   logic             dec5_w;
   logic             dec10_w;
   logic [AMT_W-1:0] rem_after_w;

`ifdef CHG_TIMEOUT_EN
   localparam int               TO_W    = $clog2(TO_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);
   logic [TO_W-1:0] to_q;
   logic            fault_q;
`endif

   assign ack_w       = (state_q == ST_PRESENT) && bus.coin_ack;
   assign dec5_w      = ack_w && (coin_type_q == COIN_5);
   assign dec10_w     = ack_w && (coin_type_q == COIN_10);
   assign rem_after_w = rem_q - AMT_W'(coin_units(coin_type_q));

   coin_stock #(.CNT_W(CNT_W), .INIT(INIT_5)) u_stock_5 (
      .clk          (clk),
      .rst          (rst),
      .refill_i     (refill_valid),
      .refill_amt_i (refill_5),
      .dec_i        (dec5_w),
      .cnt_o        (cnt_5)
   );

   coin_stock #(.CNT_W(CNT_W), .INIT(INIT_10)) u_stock_10 (
      .clk          (clk),
      .rst          (rst),
      .refill_i     (refill_valid),
      .refill_amt_i (refill_10),
      .dec_i        (dec10_w),
      .cnt_o        (cnt_10)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         rem_q        <= '0;
         coin_valid_q <= 1'b0;
         coin_type_q  <= COIN_5;
         done_q       <= 1'b0;
         shortfall_q  <= '0;
`ifdef CHG_TIMEOUT_EN
         to_q         <= '0;
         fault_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  rem_q <= bus.req_amount;
`ifdef CHG_TIMEOUT_EN
                  fault_q <= 1'b0;
`endif
                  if (bus.req_amount == '0) begin
                     shortfall_q <= '0;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_SELECT;
                  end
               end
            end
            ST_SELECT: begin
`ifdef CHG_TIMEOUT_EN
               to_q <= '0;
`endif
               // Greedy: prefer a 10 rs coin, fall back to 5 rs coins.
               if ((rem_q >= AMT_W'(2)) && (cnt_10 != '0)) begin
                  coin_type_q  <= COIN_10;
                  coin_valid_q <= 1'b1;
                  state_q      <= ST_PRESENT;
               end else if ((rem_q != '0) && (cnt_5 != '0)) begin
                  coin_type_q  <= COIN_5;
                  coin_valid_q <= 1'b1;
                  state_q      <= ST_PRESENT;
               end else begin
                  shortfall_q <= rem_q;
                  done_q      <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_PRESENT: begin
               if (bus.coin_ack) begin
                  coin_valid_q <= 1'b0;
                  rem_q        <= rem_after_w;
                  if (rem_after_w == '0) begin
                     shortfall_q <= '0;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_SELECT;
                  end
               end
`ifdef CHG_TIMEOUT_EN
               else if (to_q == TO_LAST) begin
                  coin_valid_q <= 1'b0;
                  shortfall_q  <= rem_q;
                  fault_q      <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= ST_DONE;
               end else begin
                  to_q <= to_q + TO_W'(1);
               end
`endif
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.coin_valid = coin_valid_q;
   assign bus.coin_type  = coin_type_q;
   assign done           = done_q;
   assign shortfall      = shortfall_q;
   assign low_stock      = (cnt_5 == '0) || (cnt_10 == '0);
`ifdef CHG_TIMEOUT_EN
   assign hopper_fault   = fault_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_change_dispenser : randomized bench with a transaction model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_change_dispenser;
   import vend_pkg::*;

   localparam int AMT_W = 3;
   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             refill_valid;
   logic [CNT_W-1:0] refill_5;
   logic [CNT_W-1:0] refill_10;
   logic [CNT_W-1:0] cnt_5;
   logic [CNT_W-1:0] cnt_10;
   logic             done;
   logic [AMT_W-1:0] shortfall;
   logic             low_stock;
`ifdef CHG_TIMEOUT_EN
   logic             hopper_fault;
`endif

   always #5 clk = ~clk;

   change_dispenser_if #(.AMT_W(AMT_W)) bus ();

   change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_5(16), .INIT_10(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .refill_valid (refill_valid),
      .refill_5     (refill_5),
      .refill_10    (refill_10),
      .cnt_5        (cnt_5),
      .cnt_10       (cnt_10),
      .done         (done),
      .shortfall    (shortfall),
      .low_stock    (low_stock)
`ifdef CHG_TIMEOUT_EN
      ,
      .hopper_fault (hopper_fault)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int m5, m10;
   int cyc;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   task automatic refill(input int a5, input int a10);
      refill_valid = 1'b1;
      refill_5     = CNT_W'(a5);
      refill_10    = CNT_W'(a10);
      tick();
      refill_valid = 1'b0;
      refill_5     = '0;
      refill_10    = '0;
      m5  = sat(m5 + a5);
      m10 = sat(m10 + a10);
      chk("refill_cnt5", cnt_5, m5);
      chk("refill_cnt10", cnt_10, m10);
   endtask

   // One change request; dly < 0 picks a random ack delay per coin.
   task automatic do_req(input int amt, input int dly, input bit refill_on_last);
      int rem, lat_exp, d, exp_t, n, units;
      bit aborted;
      aborted = 1'b0;
      chk("req_ready", bus.req_ready, 1);
      bus.req_valid  = 1'b1;
      bus.req_amount = amt[AMT_W-1:0];
      cyc = 0;
      tick();
      bus.req_valid = 1'b0;
`ifdef CHG_TIMEOUT_EN
      chk("fault_clear", hopper_fault, 0);
`endif
      rem     = amt;
      lat_exp = 1;
      while (rem > 0) begin
         if (rem >= 2 && m10 > 0)  exp_t = 1;
         else if (m5 > 0)          exp_t = 0;
         else                      break;
         units = exp_t ? 2 : 1;
         d = (dly < 0) ? int'($urandom_range(4, 0)) : dly;
         n = 0;
         while (!bus.coin_valid && !done && n < 20) begin
            tick();
            n++;
         end
         chk("coin_valid", bus.coin_valid, 1);
         if (!bus.coin_valid) begin
            aborted = 1'b1;
            break;
         end
         chk("coin_type", bus.coin_type, exp_t);
         for (int k = 0; k < d; k++) begin
            tick();
            chk("hold_valid", bus.coin_valid, 1);
            chk("hold_type", bus.coin_type, exp_t);
            chk("hold_cnt5", cnt_5, m5);
            chk("hold_cnt10", cnt_10, m10);
         end
         bus.coin_ack = 1'b1;
         if (refill_on_last && (rem - units == 0)) begin
            refill_valid = 1'b1;
            refill_10    = CNT_W'(10);
         end
         tick();
         bus.coin_ack = 1'b0;
         if (exp_t == 1) m10--; else m5--;
         if (refill_valid) m10 = sat(m10 + 10);
         refill_valid = 1'b0;
         refill_10    = '0;
         rem     -= units;
         lat_exp += 2 + d;
      end
      if (rem > 0) lat_exp++;
      n = 0;
      while (!done && n < 20) begin
         chk("no_extra_coin", bus.coin_valid, 0);
         tick();
         n++;
      end
      chk("done", done, 1);
      if (!aborted) chk("latency", cyc, lat_exp);
      chk("shortfall", shortfall, aborted ? -1 : rem);
      chk("cnt5", cnt_5, m5);
      chk("cnt10", cnt_10, m10);
      chk("low_stock", low_stock, (m5 == 0 || m10 == 0));
      chk("valid_at_done", bus.coin_valid, 0);
      tick();
      chk("done_pulse", done, 0);
      chk("shortfall_held", shortfall, aborted ? -1 : rem);
      chk("ready_after", bus.req_ready, 1);
   endtask

   initial begin
      int n;
      bus.req_valid  = 1'b0;
      bus.req_amount = '0;
      bus.coin_ack   = 1'b0;
      refill_valid   = 1'b0;
      refill_5       = '0;
      refill_10      = '0;
      m5  = 16;
      m10 = 16;
      tick();
      tick();
      chk("rst_coin_valid", bus.coin_valid, 0);
      chk("rst_coin_type", bus.coin_type, 0);
      chk("rst_done", done, 0);
      chk("rst_shortfall", shortfall, 0);
      chk("rst_cnt5", cnt_5, 16);
      chk("rst_cnt10", cnt_10, 16);
      chk("rst_ready", bus.req_ready, 1);
`ifdef CHG_TIMEOUT_EN
      chk("rst_fault", hopper_fault, 0);
`endif
      rst = 1'b1;
      tick();

      do_req(3, 0, 0);
      chk("t1_cnt10", cnt_10, 15);
      chk("t1_cnt5", cnt_5, 15);
      do_req(1, 0, 0);
      do_req(0, 0, 0);
      do_req(3, 5, 0);
      while (m10 > 0) do_req(2, -1, 0);
      do_req(4, 0, 0);
      while (m5 > 0) do_req(1, -1, 0);
      do_req(3, 0, 0);
      refill(0, 1);
      do_req(1, 0, 0);
      do_req(3, 0, 0);

      // Asynchronous abort while a coin is presented.
      refill(4, 4);
      bus.req_valid  = 1'b1;
      bus.req_amount = 3'd3;
      tick();
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.coin_valid && n < 10) begin
         tick();
         n++;
      end
      chk("abort_presenting", bus.coin_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_valid", bus.coin_valid, 0);
      chk("abort_cnt5", cnt_5, 16);
      chk("abort_cnt10", cnt_10, 16);
      tick();
      tick();
      rst = 1'b1;
      m5  = 16;
      m10 = 16;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("abort_no_done", done, 0);
         chk("abort_no_coin", bus.coin_valid, 0);
      end

      // Saturation when a refill coincides with a 10 rs payout.
      refill(0, 255);
      do_req(4, 0, 0);
      do_req(4, 0, 0);
      do_req(2, 0, 0);
      chk("pre_sat_cnt10", cnt_10, 250);
      do_req(2, 0, 1);
      chk("sat_cnt10", cnt_10, 255);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(2, 0) == 0) refill($urandom_range(3, 0), $urandom_range(3, 0));
         if ($urandom_range(3, 0) == 0) begin
            bus.coin_ack = 1'b1;
            tick();
            bus.coin_ack = 1'b0;
            chk("idle_ack_cnt5", cnt_5, m5);
            chk("idle_ack_cnt10", cnt_10, m10);
            chk("idle_ack_valid", bus.coin_valid, 0);
         end
         do_req($urandom_range(7, 0), -1, 0);
      end

`ifdef CHG_TIMEOUT_EN
      refill(5, 5);
      bus.req_valid  = 1'b1;
      bus.req_amount = 3'd1;
      cyc = 0;
      tick();
      bus.req_valid = 1'b0;
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      chk("to_done", done, 1);
      chk("to_latency", cyc, 257);
      chk("to_shortfall", shortfall, 1);
      chk("to_fault", hopper_fault, 1);
      chk("to_valid", bus.coin_valid, 0);
      chk("to_cnt5", cnt_5, m5);
      tick();
      do_req(1, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
